// File: rtl/c5g_qsys_dmaster_pkg.sv
// Shared framing constants and output word type for the dmaster bytes-to-packets decoder.
package c5g_qsys_dmaster_pkg;

  localparam logic [7:0] SOP_CHAR     = 8'h7A;
  localparam logic [7:0] EOP_CHAR     = 8'h7B;
  localparam logic [7:0] CHANNEL_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR     = 8'h7D;
  localparam logic [7:0] ESC_XOR      = 8'h20;

  // Channel is held at full byte width here; the top truncates it to CHANNEL_WIDTH.
  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] channel;
  } out_word_t;

endpackage

// File: rtl/c5g_qsys_mem_if_lpddr2_emif_dmaster_b2p.sv
// Avalon-ST bytes-to-packets decoder: strips SOP/EOP/channel/escape framing from a raw byte
// stream and presents a registered packetised stream.
module c5g_qsys_mem_if_lpddr2_emif_dmaster_b2p
  import c5g_qsys_dmaster_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  input  logic                     out_ready
);

  logic                     esc_q, esc_d;
  logic                     chan_pend_q, chan_pend_d;
  logic                     sop_q, sop_d;
  logic                     eop_q, eop_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic                     valid_q, valid_d;
  out_word_t                word_q, word_d;

  logic       accept;
  logic       emit;
  logic [7:0] value;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    esc_d       = esc_q;
    chan_pend_d = chan_pend_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    chan_d      = chan_q;
    valid_d     = valid_q;
    word_d      = word_q;
    emit        = 1'b0;
    value       = in_data;

    if (accept) begin
      // Escape outranks everything, so an escaped byte can never be taken as framing.
      if (esc_q) begin
        value = in_data ^ ESC_XOR;
        esc_d = 1'b0;
        if (chan_pend_q) begin
          chan_d      = value[CHANNEL_WIDTH-1:0];
          chan_pend_d = 1'b0;
        end else begin
          emit = 1'b1;
        end
      end else if (in_data == ESC_CHAR) begin
        esc_d = 1'b1;
      end else if (chan_pend_q) begin
        chan_d      = in_data[CHANNEL_WIDTH-1:0];
        chan_pend_d = 1'b0;
      end else if (in_data == SOP_CHAR) begin
        sop_d = 1'b1;
        eop_d = 1'b0;
      end else if (in_data == EOP_CHAR) begin
        eop_d = 1'b1;
      end else if (in_data == CHANNEL_CHAR) begin
        chan_pend_d = 1'b1;
      end else begin
        emit = 1'b1;
      end
    end

    if (emit) begin
      word_d.data    = value;
      word_d.sop     = sop_q;
      word_d.eop     = eop_q;
      word_d.channel = 8'(chan_q);
      sop_d          = 1'b0;
      eop_d          = 1'b0;
      valid_d        = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      esc_q       <= 1'b0;
      chan_pend_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      word_q      <= '0;
    end else begin
      esc_q       <= esc_d;
      chan_pend_q <= chan_pend_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
      word_q      <= word_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_data          = word_q.data;
  assign out_startofpacket = word_q.sop;
  assign out_endofpacket   = word_q.eop;
  assign out_channel       = word_q.channel[CHANNEL_WIDTH-1:0];

endmodule

// File: tb/tb_c5g_qsys_mem_if_lpddr2_emif_dmaster_b2p.sv
// Self-checking bench for the dmaster bytes-to-packets decoder: directed framing cases plus
// random packets encoded by the bench and checked against their original payloads.
module tb_c5g_qsys_mem_if_lpddr2_emif_dmaster_b2p;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;
  logic       out_ready = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;
  bit sb_en  = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  c5g_qsys_mem_if_lpddr2_emif_dmaster_b2p #(.CHANNEL_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_channel(out_channel),
    .out_ready(out_ready)
  );

  function automatic logic [31:0] w(input logic [7:0] d, input logic s, input logic e,
                                    input logic [7:0] c);
    return {14'b0, c, s, e, d};
  endfunction

  function automatic logic [31:0] obs();
    return {14'b0, out_channel, out_startofpacket, out_endofpacket, out_data};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One byte per cycle; returns just after the edge that accepted it.
  task automatic drive(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_seq(input logic [7:0] bs[$]);
    foreach (bs[i]) drive(bs[i]);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, obs(), exp);
  endtask

  function automatic bit is_special(input logic [7:0] b);
    return b >= 8'h7A && b <= 8'h7D;
  endfunction

  task automatic send_escaped(input logic [7:0] b);
    if (is_special(b)) begin
      drive(8'h7D);
      drive(b ^ 8'h20);
    end else begin
      drive(b);
    end
  endtask

  // Scoreboard and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && in_valid) chk("in_ready_when_valid", 32'(in_ready), 32'd1);
    if (sb_en && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_word", obs(), exp_q.pop_front());
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", obs(), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // Basic packet
    drive(8'h7A); chk("basic_ctl_novalid", 32'(out_valid), 32'd0);
    drive(8'h11); expect_word("basic_11", w(8'h11, 1, 0, 8'h00));
    drive(8'h22); expect_word("basic_22", w(8'h22, 0, 0, 8'h00));
    drive(8'h7B); chk("basic_eop_drop", 32'(out_valid), 32'd0);
    drive(8'h33); expect_word("basic_33", w(8'h33, 0, 1, 8'h00));

    // Escapes
    drive_seq('{8'h7A, 8'h7D, 8'h5A}); expect_word("esc_7A", w(8'h7A, 1, 0, 8'h00));
    drive_seq('{8'h7B, 8'h7D, 8'h5D}); expect_word("esc_7D", w(8'h7D, 0, 1, 8'h00));

    // Channel, raw then escaped
    drive_seq('{8'h7C, 8'h05, 8'h7A, 8'h7B, 8'hAA});
    expect_word("chan_5", w(8'hAA, 1, 1, 8'h05));
    drive_seq('{8'h7C, 8'h7D, 8'h5C});
    chk("chan_esc_novalid", 32'(out_valid), 32'd0);
    drive(8'h01); expect_word("chan_7C", w(8'h01, 0, 0, 8'h7C));

    // Backpressure: hold, then retire and load on the same edge
    drive(8'h11); expect_word("bp_11", w(8'h11, 0, 0, 8'h7C));
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold", obs(), w(8'h11, 0, 0, 8'h7C));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    drive(8'h22); expect_word("bp_22", w(8'h22, 0, 0, 8'h7C));

    // Mid-packet reset
    drive_seq('{8'h7A, 8'h7C});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_word", obs(), 32'd0);
    reset = 1'b0;
    drive(8'h44); expect_word("mrst_44", w(8'h44, 0, 0, 8'h00));

    // Random packets, encoded here and scored against their payloads
    @(posedge clk); #1;
    sb_en = 1'b1;
    for (int p = 0; p < 6; p++) begin
      logic [7:0] ch;
      logic [7:0] pl[$];
      ch = 8'($urandom_range(0, 255));
      pl.delete();
      for (int i = 0; i < 256; i++) begin
        // Bias toward framing values so escaping is exercised often.
        if ($urandom_range(0, 3) == 0) pl.push_back(8'($urandom_range(8'h7A, 8'h7D)));
        else pl.push_back(8'($urandom_range(0, 255)));
      end
      foreach (pl[i]) exp_q.push_back(w(pl[i], i == 0, i == pl.size() - 1, ch));
      drive(8'h7C);
      send_escaped(ch);
      drive(8'h7A);
      foreach (pl[i]) begin
        if (i == pl.size() - 1) drive(8'h7B);
        send_escaped(pl[i]);
        chk("rnd_latency", 32'(out_valid), 32'd1);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    sb_en = 1'b0;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/c5g_qsys_mem_if_lpddr2_emif_dmaster_b2p.md
# c5g_qsys_mem_if_lpddr2_emif_dmaster_b2p

Avalon-ST bytes-to-packets decoder for the LPDDR2 EMIF debug master byte path. It sits directly downstream of the dmaster timing adapter. It consumes the adapter's raw 8-bit byte stream and strips the framing characters: SOP 0x7A, EOP 0x7B, channel 0x7C, escape 0x7D. Its output is a packetised Avalon-ST stream with startofpacket, endofpacket and channel, which feeds the packets-to-transactions stage.

## Interface
Parameters:
- CHANNEL_WIDTH, 8: width of `out_channel`, range 1..8. The channel byte is truncated to its low CHANNEL_WIDTH bits.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte valid from the timing adapter.
- in_data  in  8  raw framed byte.
- in_ready  out  1  accept; drives the timing adapter's `out_ready`.
- out_valid  out  1  decoded data byte valid.
- out_data  out  8  decoded data byte.
- out_startofpacket  out  1  first byte of a packet.
- out_endofpacket  out  1  last byte of a packet.
- out_channel  out  CHANNEL_WIDTH  channel of the current byte.
- out_ready  in  1  downstream accept.

## Operation
- Handshake:
  - A byte is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`. This is combinational from `out_valid` and `out_ready` only, and never from `in_valid`.
- Decoder state (registers):
  - `esc_pending`: next byte is escaped.
  - `chan_pending`: next byte is a channel value.
  - `sop_pending`: next data byte carries SOP.
  - `eop_pending`: next data byte carries EOP.
  - `chan_reg`: current channel.
- Decoding of an accepted byte b, in priority order:
  1. `esc_pending`: the value is b^0x20 and `esc_pending` clears. If `chan_pending` is set, the value loads `chan_reg` and `chan_pending` clears. Otherwise the value is emitted as data.
  2. b==0x7D: set `esc_pending`. Nothing is emitted.
  3. `chan_pending`: load `chan_reg` with b[CHANNEL_WIDTH-1:0] and clear `chan_pending`. This applies to every byte value, special values included.
  4. b==0x7A: set `sop_pending` and clear `eop_pending`. A fresh SOP discards a stale EOP marker.
  5. b==0x7B: set `eop_pending`.
  6. b==0x7C: set `chan_pending`.
  7. Any other b: emit as data.
- Emitting data loads the output register with:
  - `out_data` = value
  - `out_startofpacket` = `sop_pending`
  - `out_endofpacket` = `eop_pending`
  - `out_channel` = `chan_reg`
- Emitting also clears `sop_pending` and `eop_pending` and sets `out_valid`.
- Sequence 0x7A,0x7B,d gives a one-byte packet with SOP=EOP=1.
- Output register:
  - Holds its value while `out_valid && !out_ready`.
  - Clears `out_valid` when `out_ready` is high and no new data byte is emitted that cycle.
- No framing-error detection. A data byte outside a packet is passed through with SOP=0.

## Timing
- Reset values: `out_valid`, `out_startofpacket`, `out_endofpacket` = 0; `out_data` = 0; `out_channel` = 0; all pending flags = 0; `chan_reg` = 0.
- Reset is honoured in any cycle. A mid-packet reset discards the pending flags and any held output byte.
- Latency: a data byte accepted at edge N is presented at `out_valid` after edge N. One cycle, registered.
- Throughput: one byte per cycle when `out_ready` stays high.
- Emit in the same cycle as `out_ready`: the old word retires and the new word loads at the same edge, with no bubble.
- Control bytes (0x7A–0x7D, channel bytes, escape targets that load the channel) consume a cycle and produce no output. `out_valid` drops if the held word retired.
- Backpressure: with `out_valid=1, out_ready=0`, `in_ready=0`. The upstream timing adapter cannot stall, so the integrator keeps `out_ready` high. The bench flags any `in_valid && !in_ready`.

## Structure
- Package `c5g_qsys_dmaster_pkg` holds:
  - the byte constants SOP_CHAR=8'h7A, EOP_CHAR=8'h7B, CHANNEL_CHAR=8'h7C, ESC_CHAR=8'h7D, ESC_XOR=8'h20;
  - the struct for the output word (data, sop, eop, channel).
- Single module, no sub-module. The decoder is a flag set rather than an encoded FSM, so a separate FSM module is not warranted.

## Test plan
- Basic packet, `out_ready`=1, bytes 7A,11,22,7B,33 → three outputs:
  - (11, sop=1, eop=0)
  - (22, 0, 0)
  - (33, 0, 1)
  - Each is valid one cycle after its accept.
- Escape: 7A,7D,5A,7B,7D,5D → outputs (7A, sop=1) then (7D, eop=1).
- Channel: 7C,05,7A,7B,AA → (AA, sop=1, eop=1, chan=5). Then 7C,7D,5C,01 → `chan_reg`=7C, next output (01, chan=7C).
- Backpressure: `out_ready`=0 after byte 11 is emitted → `in_ready`=0 and `out_data` holds 11. Raise `out_ready` together with the next byte 22 → 11 retires and 22 loads at the same edge.
- Reset mid-packet after 7A,7C: assert reset for 1 cycle, then send 44 → output (44, sop=0, eop=0, chan=0), and all outputs read 0 during reset.
- Back-to-back 256-byte random packets with escaping and `out_ready`=1 → scoreboard matches exactly, no bubbles on data bytes.
